ascon_round_ctrl: RTL and testbench

- Round scheduler for the iterative ASCON permutation datapath: constant addition, then substitution layer, then linear layer, feeding a 320-bit state register.
- Sequences p12 (12 rounds) or p6 (6 rounds) one round per clock.
- Drives the round-constant index, the state-register enable and the input-mux select.
- Signals completion to the upper-level ASCON FSM through a start/done handshake.

---
 rtl/ascon_pack.sv | 27 ++
 rtl/ascon_round_ctrl_round_counter.sv | 33 +++
 rtl/ascon_round_ctrl.sv | 98 +++++++++
 tb/tb_ascon_round_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON types and round-schedule constants
package ascon_pack;

   // Permutation round counts and index width
   localparam int NB_ROUND_A = 12;
   localparam int NB_ROUND_B = 6;
   localparam int ROUND_W    = 4;

   // Round-index subtype
   typedef logic [ROUND_W-1:0] type_round;

   // Shared 320-bit permutation state, five 64-bit words
   typedef logic [63:0] type_state [0:4];

   // Round scheduler states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } type_round_fsm;

   // First round index of a run: p^a starts at 0, p^b skips the leading rounds
   function automatic type_round first_round(input logic mode);
      first_round = mode ? type_round'(NB_ROUND_A - NB_ROUND_B) : '0;
   endfunction

endpackage

// File: rtl/ascon_round_ctrl_round_counter.sv
// rtl/ascon_round_ctrl_round_counter.sv - loadable round-index up-counter
module ascon_round_ctrl_round_counter
   import ascon_pack::*;
#(
   parameter int               WIDTH = ROUND_W,
   parameter logic [WIDTH-1:0] LAST  = WIDTH'(NB_ROUND_A - 1)
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   logic [WIDTH-1:0] count_q;

   // Load wins over increment; the counter saturates at LAST so it never wraps
   always_ff @(posedge clock) begin
      if (!resetb) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (enable && (count_q != LAST)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count    = count_q;
   assign terminal = (count_q == LAST);

endmodule

// File: rtl/ascon_round_ctrl.sv
// rtl/ascon_round_ctrl.sv - round scheduler for the iterative ASCON permutation
module ascon_round_ctrl
   import ascon_pack::*;
#(
   parameter int NB_ROUND_A = ascon_pack::NB_ROUND_A,
   parameter int NB_ROUND_B = ascon_pack::NB_ROUND_B,
   parameter int ROUND_W    = ascon_pack::ROUND_W
) (
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               start_i,
   input  logic               mode_i,
   output logic [ROUND_W-1:0] round_o,
   output logic               en_reg_state_o,
   output logic               select_init_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NB_ROUND_A - 1);
   localparam logic [ROUND_W-1:0] START_B    = ROUND_W'(NB_ROUND_A - NB_ROUND_B);

   type_round_fsm      state;
   type_round_fsm      next_state;
   logic               first;
   logic               accept;
   logic [ROUND_W-1:0] count;
   logic               last;
   logic [ROUND_W-1:0] load_value;

   // The mode only matters for the counter's starting index, so it is captured
   // by the counter load itself; later mode_i changes cannot reach the schedule.
   assign accept     = (state == IDLE) && start_i;
   assign load_value = mode_i ? START_B : '0;

   ascon_round_ctrl_round_counter #(
      .WIDTH (ROUND_W),
      .LAST  (LAST_ROUND)
   ) u_round_counter (
      .clock      (clock_i),
      .resetb     (resetb_i),
      .load       (accept),
      .load_value (load_value),
      .enable     (state == RUN),
      .count      (count),
      .terminal   (last)
   );

   // State register
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // First-round flag: set on acceptance, cleared by the first RUN edge
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         first <= 1'b0;
      end else begin
         first <= accept;
      end
   end

   // Next-state and Moore output decode; unknown encodings behave as IDLE
   always_comb begin
      next_state     = IDLE;
      round_o        = '0;
      en_reg_state_o = 1'b0;
      select_init_o  = 1'b0;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      case (state)
         IDLE: begin
            next_state = start_i ? RUN : IDLE;
         end
         RUN: begin
            en_reg_state_o = 1'b1;
            busy_o         = 1'b1;
            round_o        = count;
            select_init_o  = first;
            next_state     = last ? DONE : RUN;
         end
         DONE: begin
            done_o     = 1'b1;
            busy_o     = 1'b1;
            round_o    = LAST_ROUND;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// tb/tb_ascon_round_ctrl.sv - scoreboard bench for the ASCON round scheduler
module tb_ascon_round_ctrl;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] round;
   logic       en_reg_state;
   logic       select_init;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] round;
      logic       sel;
      logic       done;
   } exp_t;

   exp_t exp_q[$];

   logic [319:0] init_st = {64'h80400c0600000000, 64'h0001020304050607,
                            64'h08090a0b0c0d0eff, 64'h0011223344556677,
                            64'h8899aabbccddeeff};
   logic [319:0] dp_st = '0;
   logic [319:0] golden;

   ascon_round_ctrl dut (
      .clock_i        (clk),
      .resetb_i       (resetb),
      .start_i        (start),
      .mode_i         (mode),
      .round_o        (round),
      .en_reg_state_o (en_reg_state),
      .select_init_o  (select_init),
      .busy_o         (busy),
      .done_o         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      ror = (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [319:0] ascon_round(input logic [319:0] s, input int r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [7:0]  c;
      {x0, x1, x2, x3, x4} = s;
      c  = 8'((15 - r) * 16 + r);
      x2 = x2 ^ {56'd0, c};
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = x0 ^ (~x1 & x2);
      t1 = x1 ^ (~x2 & x3);
      t2 = x2 ^ (~x3 & x4);
      t3 = x3 ^ (~x4 & x0);
      t4 = x4 ^ (~x0 & x1);
      t1 = t1 ^ t0;
      t0 = t0 ^ t4;
      t3 = t3 ^ t2;
      t2 = ~t2;
      x0 = t0 ^ ror(t0, 19) ^ ror(t0, 28);
      x1 = t1 ^ ror(t1, 61) ^ ror(t1, 39);
      x2 = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
      x3 = t3 ^ ror(t3, 10) ^ ror(t3, 17);
      x4 = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
      ascon_round = {x0, x1, x2, x3, x4};
   endfunction

   // Permutation datapath model steered only by the controller outputs
   always @(posedge clk) begin
      if (en_reg_state === 1'b1)
         dp_st <= ascon_round(select_init ? init_st : dp_st, int'(round));
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every enabled or done cycle must match the head of the queue
   always @(negedge clk) begin
      exp_t e;
      if (en_reg_state === 1'b1 || done === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: round=%0d en=%b sel=%b done=%b", round, en_reg_state, select_init, done);
         end else begin
            e = exp_q.pop_front();
            if (round !== e.round || select_init !== e.sel || done !== e.done ||
                en_reg_state !== !e.done || busy !== 1'b1) begin
               bad++;
               $display("FAIL sequence: got round=%0d en=%b sel=%b done=%b busy=%b expected round=%0d sel=%b done=%b busy=1",
                        round, en_reg_state, select_init, done, busy, e.round, e.sel, e.done);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input logic m);
      int n;
      int s;
      n = m ? 6 : 12;
      s = m ? 6 : 0;
      for (int i = 0; i < n; i++)
         exp_q.push_back('{round: 4'(s + i), sel: (i == 0), done: 1'b0});
      exp_q.push_back('{round: 4'd11, sel: 1'b0, done: 1'b1});
   endtask

   task automatic check_idle(input string name);
      check(name, 64'({round, en_reg_state, select_init, busy, done}), 64'd0);
   endtask

   // One permutation; pulse_mask bit k drives start during cycle k after acceptance
   task automatic run(input logic m, input logic [31:0] pulse_mask, input logic tog, input string name);
      int n;
      int k;
      n = m ? 6 : 12;
      push_run(m);
      start = 1'b1;
      mode  = m;
      tick();
      k = 1;
      while (done !== 1'b1 && k < 40) begin
         start = pulse_mask[k];
         if (tog) mode = ~mode;
         tick();
         k++;
      end
      check({name, "_latency"}, 64'(k), 64'(n + 1));
      start = pulse_mask[k];
      tick();
      start = 1'b0;
      check_idle({name, "_idle_after"});
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      // Reset held with start high
      resetb = 1'b0;
      start  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("reset_hold");
      end
      start  = 1'b0;
      resetb = 1'b1;
      tick();
      check_idle("reset_release");

      // p12 integrated with the datapath model
      golden = init_st;
      for (int r = 0; r < 12; r++) golden = ascon_round(golden, r);
      run(1'b0, 32'd0, 1'b0, "p12");
      for (int w = 0; w < 5; w++)
         check($sformatf("p12_state_x%0d", w), dp_st[319 - 64*w -: 64], golden[319 - 64*w -: 64]);

      // p6 with mode toggling during RUN
      run(1'b1, 32'd0, 1'b1, "p6_toggle");

      // Ignored starts at rounds 3 and 11 and in DONE
      run(1'b0, (32'd1 << 4) | (32'd1 << 12) | (32'd1 << 13), 1'b0, "ignored_start");

      // Reset mid p12 at round 5
      push_run(1'b0);
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("midreset_round5", 64'(round), 64'd5);
      resetb = 1'b0;
      tick();
      exp_q.delete();
      check_idle("midreset_in_reset");
      resetb = 1'b1;
      tick();
      check_idle("midreset_released");
      repeat (16) tick();

      // p6 after an aborted run
      run(1'b1, 32'd0, 1'b0, "p6_after_reset");

      // Back-to-back: start held through DONE relaunches after one IDLE bubble
      push_run(1'b1);
      push_run(1'b1);
      start = 1'b1;
      mode  = 1'b1;
      repeat (9) tick();
      start = 1'b0;
      repeat (6) tick();
      check("b2b_second_done", 64'(done), 64'd1);
      tick();
      check_idle("b2b_idle_after");
      repeat (3) tick();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
